tema_3_2b: RTL and testbench

Switch-to-LED code converter for the board I/O layer. It samples three asynchronous slide switches and treats them as a 3-bit unsigned number N. It drives four LEDs with the 4-bit excess-3 code of N (N + 3). Inputs are synchronized and optionally debounced, and outputs are registered so the LEDs never glitch.

---
 rtl/tema_3_2b_pkg.sv | 13 +
 rtl/tema_3_2b_if.sv | 13 +
 rtl/tema_3_2b_sw_conditioner.sv | 64 ++++++
 rtl/tema_3_2b.sv | 38 +++
 tb/tb_tema_3_2b.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/tema_3_2b_pkg.sv
// Shared widths, defaults and the excess-3 conversion for the switch-to-LED converter.
package tema3_pkg;
    localparam int N_W               = 3;
    localparam int R_W               = 4;
    localparam int EXCESS            = 3;
    localparam int SYNC_STAGES_DEF   = 2;
    localparam int STABLE_CYCLES_DEF = 0;

    // N is at most 7, so N + 3 always fits in R_W bits.
    function automatic logic [R_W-1:0] to_excess3(input logic [N_W-1:0] n);
        return R_W'(n) + R_W'(EXCESS);
    endfunction
endpackage

// File: rtl/tema_3_2b_if.sv
// Board I/O bundle: three slide switches in, four LEDs out.
interface tema_3_2b_if;
    logic sw0;
    logic sw1;
    logic sw2;
    logic led0;
    logic led1;
    logic led2;
    logic led3;

    modport master (output sw0, sw1, sw2, input  led0, led1, led2, led3);
    modport slave  (input  sw0, sw1, sw2, output led0, led1, led2, led3);
endinterface

// File: rtl/tema_3_2b_sw_conditioner.sv
// Per-bit synchronizer chain followed by an optional stability filter.
// Latency SYNC_STAGES edges (filter bypassed) or SYNC_STAGES + STABLE_CYCLES + 1 edges.
module sw_conditioner
    import tema3_pkg::*;
#(
    parameter int WIDTH         = N_W,
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] acc_o
);
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= raw_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    generate
        if (STABLE_CYCLES == 0) begin : g_bypass
            assign acc_o = sync_s;
        end else begin : g_filter
            localparam int             CW      = $clog2(STABLE_CYCLES + 1);
            localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);

            logic [WIDTH-1:0] prev_q, acc_q, acc_d;
            logic [CW-1:0]    cnt_q, cnt_d;

            // Accept on the edge where the counter reaches its limit, so the
            // value must have matched its predecessor for STABLE_CYCLES+1 edges.
            always_comb begin
                cnt_d = cnt_q;
                acc_d = acc_q;
                if (sync_s != prev_q)    cnt_d = '0;
                else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                if (cnt_d == CNT_MAX && sync_s != acc_q) acc_d = sync_s;
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    prev_q <= '0;
                    cnt_q  <= '0;
                    acc_q  <= '0;
                end else begin
                    prev_q <= sync_s;
                    cnt_q  <= cnt_d;
                    acc_q  <= acc_d;
                end
            end

            assign acc_o = acc_q;
        end
    endgenerate
endmodule

// File: rtl/tema_3_2b.sv
// Switch-to-LED excess-3 converter: conditioned 3-bit switch word in, registered N+3 on four LEDs.
// LEDs read 0000 only while in reset; after that they always show a legal code 0011..1010.
module tema_3_2b
    import tema3_pkg::*;
#(
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    tema_3_2b_if.slave  io
);
    logic [N_W-1:0] sw_raw;
    logic [N_W-1:0] sw_acc;
    logic [R_W-1:0] led_d, led_q;

    assign sw_raw = {io.sw0, io.sw1, io.sw2};

    sw_conditioner #(
        .WIDTH         (N_W),
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_cond (
        .clk   (clk),
        .rst_n (rst_n),
        .raw_i (sw_raw),
        .acc_o (sw_acc)
    );

    assign led_d = to_excess3(sw_acc);

    always_ff @(posedge clk) begin
        if (!rst_n) led_q <= '0;
        else        led_q <= led_d;
    end

    assign {io.led0, io.led1, io.led2, io.led3} = led_q;
endmodule

// File: tb/tb_tema_3_2b.sv
// Directed bench: a default instance and a debounced (STABLE_CYCLES=4) instance share clock and reset.
module tb_tema_3_2b;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [3:0] led_def, led_dbc;
    logic [3:0] exp_tbl [8] = '{4'b0011, 4'b0100, 4'b0101, 4'b0110,
                                4'b0111, 4'b1000, 4'b1001, 4'b1010};

    always #5 clk = ~clk;

    tema_3_2b_if io_d ();
    tema_3_2b_if io_b ();

    tema_3_2b u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io_d)
    );

    tema_3_2b #(.SYNC_STAGES(2), .STABLE_CYCLES(4)) u_dut_db (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io_b)
    );

    assign led_def = {io_d.led0, io_d.led1, io_d.led2, io_d.led3};
    assign led_dbc = {io_b.led0, io_b.led1, io_b.led2, io_b.led3};

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, want %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sw(input logic [2:0] v);
        {io_d.sw0, io_d.sw1, io_d.sw2} = v;
    endtask

    task automatic set_swd(input logic [2:0] v);
        {io_b.sw0, io_b.sw1, io_b.sw2} = v;
    endtask

    initial begin
        rst_n = 1'b0;
        set_sw(3'b101);
        set_swd(3'b000);

        // Reset held for three edges with switches at 101
        repeat (3) tick();
        chk("reset_def", led_def, 4'b0000);
        chk("reset_db",  led_dbc, 4'b0000);

        rst_n = 1'b1;
        tick();
        chk("rel_e1_def", led_def, 4'b0011);
        chk("rel_e1_db",  led_dbc, 4'b0011);
        tick();
        chk("rel_e2_def", led_def, 4'b0011);
        tick();
        chk("rel_e3_def", led_def, 4'b1000);

        // One switch value per period; each LED word lags by three edges
        for (int j = 0; j < 10; j++) begin
            set_sw((j < 8) ? 3'(j) : 3'b111);
            tick();
            if (j >= 2) chk("sweep", led_def, exp_tbl[j-2]);
        end

        // Single 000 -> 111 step
        set_sw(3'b000);
        repeat (4) tick();
        chk("lat_idle", led_def, 4'b0011);
        set_sw(3'b111);
        tick();
        chk("lat_e1", led_def, 4'b0011);
        tick();
        chk("lat_e2", led_def, 4'b0011);
        tick();
        chk("lat_e3", led_def, 4'b1010);
        repeat (3) begin
            tick();
            chk("lat_hold", led_def, 4'b1010);
        end

        // sw2 rises one cycle ahead of sw0
        set_sw(3'b000);
        repeat (4) tick();
        chk("stag_idle", led_def, 4'b0011);
        set_sw(3'b001);
        tick();
        chk("stag_e1", led_def, 4'b0011);
        set_sw(3'b101);
        tick();
        chk("stag_e2", led_def, 4'b0011);
        tick();
        chk("stag_e3", led_def, 4'b0100);
        tick();
        chk("stag_e4", led_def, 4'b1000);
        repeat (3) begin
            tick();
            chk("stag_range", (led_def >= 4'd3 && led_def <= 4'd10) ? 4'd1 : 4'd0, 4'd1);
            chk("stag_hold", led_def, 4'b1000);
        end

        // Debounced instance: a two-cycle pulse must be filtered out
        set_swd(3'b111);
        tick();
        tick();
        set_swd(3'b000);
        repeat (12) begin
            tick();
            chk("db_pulse", led_dbc, 4'b0011);
        end

        // Held 111 appears after eight edges
        set_swd(3'b111);
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("db_hold_wait", led_dbc, 4'b0011);
        end
        tick();
        chk("db_hold", led_dbc, 4'b1010);

        // Reset while a new value (110) is partway through the stable window
        set_swd(3'b110);
        repeat (4) tick();
        chk("db_mid_pending", led_dbc, 4'b1010);
        rst_n = 1'b0;
        tick();
        chk("db_mid_rst",  led_dbc, 4'b0000);
        chk("def_mid_rst", led_def, 4'b0000);
        rst_n = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("db_rst_wait", led_dbc, 4'b0011);
        end
        tick();
        chk("db_rst_done", led_dbc, 4'b1001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
